// File: rtl/serial_word_loader_pkg.sv
// ============================================================================
// Module      : serial_word_loader_pkg
// Description : Shared constants and helpers for the serial/parallel word
//               converters (bit order selectors, counter width function).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_word_loader_pkg;

    localparam int c_MSB_FIRST = 1;
    localparam int c_LSB_FIRST = 0;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n < 2) return 1;
        return $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_loader_if.sv
// ============================================================================
// Module      : serial_word_loader_if
// Description : Serial input / parallel word output bundle of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_word_loader_if #(
    parameter int N = 4
);
    import serial_word_loader_pkg::*;

    localparam int CW = cnt_width(N);

    logic          sin;
    logic          sin_valid;
    logic          abort;
    logic [N-1:0]  P;
    logic          load;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    modport master (
        output sin, sin_valid, abort,
        input  P, load, busy, bit_cnt
    );

    modport slave (
        input  sin, sin_valid, abort,
        output P, load, busy, bit_cnt
    );

endinterface

`default_nettype wire

// File: rtl/serial_word_loader_sipo_shift_reg.sv
// ============================================================================
// Module      : sipo_shift_reg
// Description : Serial-in parallel-out shift register with clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shift_reg
    import serial_word_loader_pkg::*;
#(
    parameter int N         = 4,
    parameter int MSB_FIRST = c_MSB_FIRST
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clr,
    input  wire logic         shift_en,
    input  wire logic         sin,
    output logic [N-1:0]      q
);

    logic [N-1:0] sh_d;
    logic [N-1:0] sh_q;
    logic [N-1:0] w_shifted;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {sh_q[N-2:0], sin};
        end else begin : g_lsb_first
            assign w_shifted = {sin, sh_q[N-1:1]};
        end
    endgenerate

    always_comb begin
        sh_d = sh_q;
        if (clr) begin
            sh_d = '0;
        end else if (shift_en) begin
            sh_d = w_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q = sh_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_loader.sv
// ============================================================================
// Module      : serial_word_loader
// Description : Deserialises a qualified bit stream into N-bit words and
//               pulses load for one clock with each completed word on P.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int N         = 4,
    parameter int MSB_FIRST = c_MSB_FIRST
) (
    input  wire logic             clk,
    input  wire logic             reset,
    serial_word_loader_if.slave   bus
);

    localparam int            CW     = cnt_width(N);
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    logic [N-1:0]  sh;
    logic [N-1:0]  w_shifted;
    logic          w_accept;

    logic [CW-1:0] bit_cnt_d, bit_cnt_q;
    logic [N-1:0]  p_d, p_q;
    logic          load_d, load_q;
    logic          busy_d, busy_q;

    assign w_accept = bus.sin_valid & ~bus.abort;

    sipo_shift_reg #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.abort),
        .shift_en (w_accept),
        .sin      (bus.sin),
        .q        (sh)
    );

    // P must capture the word including the bit arriving on this edge.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {sh[N-2:0], bus.sin};
        end else begin : g_lsb_first
            assign w_shifted = {bus.sin, sh[N-1:1]};
        end
    endgenerate

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        p_d       = p_q;
        load_d    = 1'b0;
        if (bus.abort) begin
            bit_cnt_d = '0;
        end else if (bus.sin_valid) begin
            if (bit_cnt_q == c_LAST) begin
                bit_cnt_d = '0;
                p_d       = w_shifted;
                load_d    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
        busy_d = (bit_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= '0;
            p_q       <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            p_q       <= p_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.P       = p_q;
    assign bus.load    = load_q;
    assign bus.busy    = busy_q;
    assign bus.bit_cnt = bit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_loader.sv
// ============================================================================
// Module      : tb_serial_word_loader
// Description : Scoreboard bench for serial_word_loader, MSB- and LSB-first
//               instances fed the same stream, plus a downstream register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_word_loader;
    import serial_word_loader_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic       load;
        logic [1:0] cnt;
        logic       busy;
        logic [3:0] pm;
        logic [3:0] pl;
        logic [3:0] rg;
    } status_t;

    typedef struct {
        logic [3:0] wm;
        logic [3:0] wl;
    } word_t;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] reg_q;

    serial_word_loader_if #(.N(N)) bus_m ();
    serial_word_loader_if #(.N(N)) bus_l ();

    serial_word_loader #(.N(N), .MSB_FIRST(c_MSB_FIRST)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m)
    );

    serial_word_loader #(.N(N), .MSB_FIRST(c_LSB_FIRST)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    always #5 clk = ~clk;

    // Downstream parallel-load register fed by the MSB-first instance.
    always @(posedge clk) begin
        if (reset) reg_q <= 4'd0;
        else if (bus_m.load) reg_q <= bus_m.P;
    end

    status_t sq[$];
    word_t   wq[$];
    int      n_checks = 0;
    int      n_pass   = 0;

    // Reference model state: bits of the word in progress, in arrival order.
    bit         m_bits[$];
    logic [3:0] m_pm  = 4'd0;
    logic [3:0] m_pl  = 4'd0;
    logic [3:0] m_reg = 4'd0;
    logic       m_load = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit r, input bit v, input bit s, input bit a);
        status_t st;
        word_t   w;
        @(negedge clk);
        reset          = r;
        bus_m.sin_valid = v; bus_l.sin_valid = v;
        bus_m.sin       = s; bus_l.sin       = s;
        bus_m.abort     = a; bus_l.abort     = a;
        if (r) begin
            m_bits.delete();
            m_pm = 4'd0; m_pl = 4'd0; m_reg = 4'd0; m_load = 1'b0;
        end else begin
            if (m_load) m_reg = m_pm;
            m_load = 1'b0;
            if (a) begin
                m_bits.delete();
            end else if (v) begin
                m_bits.push_back(s);
                if (m_bits.size() == N) begin
                    w.wm = 4'd0; w.wl = 4'd0;
                    for (int i = 0; i < N; i++) begin
                        w.wm = (w.wm << 1) | 4'(m_bits[i]);
                        w.wl = w.wl | (4'(m_bits[i]) << i);
                    end
                    m_pm = w.wm; m_pl = w.wl; m_load = 1'b1;
                    wq.push_back(w);
                    m_bits.delete();
                end
            end
        end
        st.load = m_load;
        st.cnt  = 2'(m_bits.size());
        st.busy = (m_bits.size() != 0);
        st.pm   = m_pm;
        st.pl   = m_pl;
        st.rg   = m_reg;
        sq.push_back(st);
    endtask

    task automatic send(input logic [3:0] bits, input int gap);
        for (int i = 3; i >= 0; i--) begin
            step(0, 1, bits[i], 0);
            for (int g = 0; g < gap; g++) step(0, 0, 0, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Monitor: one status entry per clock, one word entry per load pulse.
    initial begin
        status_t st;
        word_t   w;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                st = sq.pop_front();
                chk("load_m",  32'(bus_m.load),    32'(st.load));
                chk("load_l",  32'(bus_l.load),    32'(st.load));
                chk("cnt_m",   32'(bus_m.bit_cnt), 32'(st.cnt));
                chk("cnt_l",   32'(bus_l.bit_cnt), 32'(st.cnt));
                chk("busy_m",  32'(bus_m.busy),    32'(st.busy));
                chk("busy_l",  32'(bus_l.busy),    32'(st.busy));
                chk("P_m",     32'(bus_m.P),       32'(st.pm));
                chk("P_l",     32'(bus_l.P),       32'(st.pl));
                chk("reg_Q",   32'(reg_q),         32'(st.rg));
            end
            if (bus_m.load === 1'b1 || bus_l.load === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("unexpected_load", 32'(1), 32'(0));
                end else begin
                    w = wq.pop_front();
                    chk("word_m", 32'(bus_m.P), 32'(w.wm));
                    chk("word_l", 32'(bus_l.P), 32'(w.wl));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_m.sin = 0; bus_m.sin_valid = 0; bus_m.abort = 0;
        bus_l.sin = 0; bus_l.sin_valid = 0; bus_l.abort = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(2);
        // Basic word, both bit orders.
        send(4'b1011, 0);
        idle(2);
        // Idle gaps inside a word.
        for (int g = 0; g < 4; g++) begin
            send(4'b1011, g);
            idle(1);
        end
        // Abort mid-word, then abort on the Nth-bit cycle.
        step(0, 1, 1, 0); step(0, 1, 1, 0);
        step(0, 0, 0, 1);
        send(4'b0110, 0);
        idle(1);
        step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
        step(0, 1, 1, 1);
        idle(2);
        // Back-to-back words.
        send(4'b1001, 0);
        send(4'b0111, 0);
        idle(2);
        // Reset mid-word after a completed word.
        send(4'b1011, 0);
        step(0, 1, 1, 0); step(0, 1, 0, 0);
        step(1, 1, 1, 0);
        send(4'b0110, 0);
        idle(2);
        // Downstream register capture and hold.
        send(4'b0101, 0);
        step(0, 1, 1, 0); step(0, 1, 0, 0);
        idle(3);
        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            automatic int r = $urandom_range(0, 99);
            step(r < 1, $urandom_range(0, 99) < 65, 1'($urandom), $urandom_range(0, 99) < 5);
        end
        idle(4);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(wq.size() + sq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
